line_drawer: RTL and testbench
==============================

# line_drawer

Parametrised pixel-walk generator for the game-board datapath: given an origin, extents and a mode, it emits one (x, y) coordinate per cycle for a horizontal line, vertical line, filled rectangle or rectangle outline. A start/busy/done handshake and a downstream stall make it the single drawing engine feeding the VGA plot path, replacing fixed-width per-shape counters.

## Interface
- COORD_W, 5, width of x/y coordinates; sums wrap modulo 2^COORD_W
- LEN_W, 5, width of width/height extents
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears state and outputs
- start  in  1  request a draw; sampled only in IDLE
- mode  in  2  00 horizontal line, 01 vertical line, 10 filled rect, 11 outline rect
- x, y  in  COORD_W  origin (top-left), latched on accepted start
- width  in  LEN_W  x extent minus one (inclusive), latched on start
- height  in  LEN_W  y extent minus one (inclusive), latched on start
- stall  in  1  downstream not ready; current pixel held while high
- busy  out  1  high in DRAW and DONE
- plot  out  1  current xOut/yOut is a pixel to write
- xOut, yOut  out  COORD_W  current pixel coordinate
- done  out  1  one-cycle pulse after the last pixel

## Operation
- States: IDLE, DRAW, DONE. Reset -> IDLE; busy=0, plot=0, done=0, counters and latched origin 0 so xOut=yOut=0.
- IDLE: start=1 latches x, y, width, height, mode; xcnt=ycnt=0; next DRAW.
- Walk order is column-major: ycnt advances fastest; when ycnt reaches y-limit it clears and xcnt increments.
- Limits per mode: 00 x-limit=width, y-limit=0; 01 x-limit=0, y-limit=height; 10/11 x-limit=width, y-limit=height. width/height ignored where limit is 0.
- xOut = x_latched + xcnt, yOut = y_latched + ycnt, truncated to COORD_W (wrap, no saturation).
- DRAW: plot=1 except in mode 11 for interior pixels (0<xcnt<width and 0<ycnt<height), where plot=0.
- Advance: plot=1 pixel advances only when stall=0; plot=0 interior pixel advances regardless of stall.
- Last pixel (xcnt=x-limit, ycnt=y-limit) accepted -> DONE; DONE asserts done=1 for exactly one cycle, next IDLE.
- start while busy ignored (not queued). start in the DONE cycle ignored.
- Extents 0/0 produce exactly one pixel at the origin.
- reset mid-draw: next cycle IDLE, all outputs at reset values, no done pulse.

## Timing
- Start accepted at edge 0 -> first pixel valid after edge 1 (one-cycle latency).
- Pixel count P = (x-limit+1)*(y-limit+1); with no stall, done high in cycle P+1 after start, back in IDLE at P+2.
- Each stall cycle on a plot=1 pixel adds one cycle; outputs stable while stalled.
- Outputs are decoded from registers only; stall does not combinationally affect xOut/yOut.

## Configuration
- LINE_DRAWER_OUTLINE_EN defined: mode 11 draws outline as above.
- Not defined: interior-suppression logic omitted; mode 11 behaves identically to mode 10 (filled).

## Structure
- Package line_drawer_pkg: mode encodings (MODE_HLINE, MODE_VLINE, MODE_FILL, MODE_OUTLINE) and state enum (IDLE, DRAW, DONE).
- One sub-module: span_counter, nested x/y counter with limits, advance enable and last flag; FSM, latching and output adders stay in line_drawer.

## Test plan
- Vertical: x=3, y=4, height=2, mode 01 -> plots (3,4),(3,5),(3,6) on cycles 1-3, done on cycle 4.
- Wrap: COORD_W=5, x=30, y=0, width=3, mode 00 -> xOut 30,31,0,1, yOut 0.
- Fill: x=0, y=0, width=1, height=1, mode 10 -> (0,0),(0,1),(1,0),(1,1), done cycle 5.
- Outline (macro on): width=2, height=2 -> 8 plots, (1,1) with plot=0; macro off -> 9 plots.
- Stall: stall high 2 cycles on second pixel of vertical line -> pixel held, done delayed by 2; start pulsed mid-draw ignored.
- Reset mid-fill after 2 pixels -> next cycle busy=0, plot=0, xOut=yOut=0, no done; new start runs normally.

Source files
------------

// File: rtl/line_drawer_pkg.sv
// Shared encodings for the line_drawer pixel-walk engine: draw modes and FSM states.
package line_drawer_pkg;

  typedef enum logic [1:0] {
    MODE_HLINE   = 2'b00,
    MODE_VLINE   = 2'b01,
    MODE_FILL    = 2'b10,
    MODE_OUTLINE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DRAW = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/line_drawer_span_counter.sv
// Nested column-major x/y counter: y advances fastest, x steps when y wraps at its limit.
module span_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] x_lim,
  input  logic [W-1:0] y_lim,
  output logic [W-1:0] xcnt,
  output logic [W-1:0] ycnt,
  output logic         last
);

  logic [W-1:0] xcnt_q, xcnt_d;
  logic [W-1:0] ycnt_q, ycnt_d;

  assign xcnt = xcnt_q;
  assign ycnt = ycnt_q;
  assign last = (xcnt_q == x_lim) && (ycnt_q == y_lim);

  // The final pixel holds its position so the outputs stay put through DONE.
  always_comb begin
    xcnt_d = xcnt_q;
    ycnt_d = ycnt_q;
    if (clear) begin
      xcnt_d = '0;
      ycnt_d = '0;
    end else if (advance && !last) begin
      if (ycnt_q == y_lim) begin
        ycnt_d = '0;
        xcnt_d = xcnt_q + 1'b1;
      end else begin
        ycnt_d = ycnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xcnt_q <= '0;
      ycnt_q <= '0;
    end else begin
      xcnt_q <= xcnt_d;
      ycnt_q <= ycnt_d;
    end
  end

endmodule

// File: rtl/line_drawer.sv
// Pixel-walk generator (hline/vline/fill/outline) with start/busy/done and stall.
// Define LINE_DRAWER_OUTLINE_EN to enable interior suppression for outline mode.
module line_drawer
  import line_drawer_pkg::*;
#(
  parameter int COORD_W = 5,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [LEN_W-1:0]   width,
  input  logic [LEN_W-1:0]   height,
  input  logic               stall,
  output logic               busy,
  output logic               plot,
  output logic [COORD_W-1:0] xOut,
  output logic [COORD_W-1:0] yOut,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for start; operands latched on accept
  // DRAW  | walking pixels, one per accepted cycle
  // DONE  | one-cycle done pulse, start ignored

  state_e              state_q, state_d;
  mode_e               mode_q;
  logic [COORD_W-1:0]  x_q, y_q;
  logic [LEN_W-1:0]    width_q, height_q;
  logic                latch_en;
  logic                cnt_clear, cnt_adv, cnt_last;
  logic [LEN_W-1:0]    x_lim, y_lim, xcnt, ycnt;
  logic                interior;
  logic                plot_int;

  assign x_lim = (mode_q == MODE_VLINE) ? '0 : width_q;
  assign y_lim = (mode_q == MODE_HLINE) ? '0 : height_q;

  span_counter #(.W(LEN_W)) u_span (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .x_lim   (x_lim),
    .y_lim   (y_lim),
    .xcnt    (xcnt),
    .ycnt    (ycnt),
    .last    (cnt_last)
  );

`ifdef LINE_DRAWER_OUTLINE_EN
  assign interior = (mode_q == MODE_OUTLINE) &&
                    (xcnt != '0) && (xcnt != width_q) &&
                    (ycnt != '0) && (ycnt != height_q);
`else
  assign interior = 1'b0;
`endif

  assign plot_int = (state_q == DRAW) && !interior;

  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_en  = 1'b1;
          cnt_clear = 1'b1;
          state_d   = DRAW;
        end
      end
      DRAW: begin
        // Suppressed interior pixels never wait on the downstream stall.
        cnt_adv = plot_int ? !stall : 1'b1;
        if (cnt_adv && cnt_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_HLINE;
      x_q      <= '0;
      y_q      <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        mode_q   <= mode_e'(mode);
        x_q      <= x;
        y_q      <= y;
        width_q  <= width;
        height_q <= height;
      end
    end
  end

  assign busy = (state_q == DRAW) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign plot = plot_int;
  assign xOut = x_q + COORD_W'(xcnt);
  assign yOut = y_q + COORD_W'(ycnt);

endmodule

// File: tb/tb_line_drawer.sv
// Randomized self-checking bench for line_drawer against a shape-level pixel-list model.
module tb_line_drawer;

  localparam int COORD_W = 5;
  localparam int LEN_W   = 5;
  localparam int CMOD    = 1 << COORD_W;

`ifdef LINE_DRAWER_OUTLINE_EN
  localparam bit OUTLINE_ON = 1'b1;
`else
  localparam bit OUTLINE_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset, start, stall;
  logic [1:0]         mode;
  logic [COORD_W-1:0] x, y;
  logic [LEN_W-1:0]   width, height;
  logic               busy, plot, done;
  logic [COORD_W-1:0] xOut, yOut;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  line_drawer #(.COORD_W(COORD_W), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .x      (x),
    .y      (y),
    .width  (width),
    .height (height),
    .stall  (stall),
    .busy   (busy),
    .plot   (plot),
    .xOut   (xOut),
    .yOut   (yOut),
    .done   (done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input int m, input int ox, input int oy, input int w, input int h);
    @(negedge clk);
    start  = 1'b1;
    mode   = 2'(m);
    x      = COORD_W'(ox);
    y      = COORD_W'(oy);
    width  = LEN_W'(w);
    height = LEN_W'(h);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_pix(input string nm, input int px, input int py);
    chk({nm, " plot"}, int'(plot), 1);
    chk({nm, " x"}, int'(xOut), px);
    chk({nm, " y"}, int'(yOut), py);
    @(negedge clk);
  endtask

  // Model: the shape as an ordered list of pixels, each flagged written or skipped.
  // Returns the number of cycles spent in DRAW and the number of written pixels.
  task automatic run_draw(input int m, input int ox, input int oy, input int w, input int h,
                          input int stall_pct, input int stall_idx, input int stall_cnt,
                          input bit poke, output int cycles, output int nplots);
    int ex[$], ey[$], ep[$];
    int xl, yl, idx, held;
    bit st;
    xl = (m == 1) ? 0 : w;
    yl = (m == 0) ? 0 : h;
    for (int i = 0; i <= xl; i++)
      for (int j = 0; j <= yl; j++) begin
        ex.push_back((ox + i) % CMOD);
        ey.push_back((oy + j) % CMOD);
        ep.push_back((OUTLINE_ON && m == 3 && i > 0 && i < w && j > 0 && j < h) ? 0 : 1);
      end
    nplots = 0;
    foreach (ep[k]) nplots += ep[k];
    issue(m, ox, oy, w, h);
    idx = 0; held = 0; cycles = 0;
    while (idx < ep.size() && cycles < 3000) begin
      chk("draw busy", int'(busy), 1);
      chk("draw done", int'(done), 0);
      chk("draw plot", int'(plot), ep[idx]);
      if (ep[idx] == 1) begin
        chk("draw xOut", int'(xOut), ex[idx]);
        chk("draw yOut", int'(yOut), ey[idx]);
      end
      st = ($urandom_range(99) < stall_pct);
      if (idx == stall_idx && held < stall_cnt) begin
        st = 1'b1;
        held++;
      end
      stall = st;
      start = poke && ($urandom_range(3) == 0);
      x = COORD_W'($urandom); y = COORD_W'($urandom);
      width = LEN_W'($urandom); height = LEN_W'($urandom); mode = 2'($urandom);
      if (ep[idx] == 0 || !st) idx++;
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 3000) chk("draw cycle budget", cycles, -1);
    chk("done pulse", int'(done), 1);
    chk("done busy", int'(busy), 1);
    chk("done plot", int'(plot), 0);
    stall = 1'b0;
    start = poke;
    @(negedge clk);
    start = 1'b0;
    chk("idle busy", int'(busy), 0);
    chk("idle done", int'(done), 0);
  endtask

  initial begin
    int cyc, np, m, w, h, ox, oy;
    reset = 1'b1; start = 1'b0; stall = 1'b0; mode = '0;
    x = '0; y = '0; width = '0; height = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset plot", int'(plot), 0);
    chk("reset done", int'(done), 0);
    chk("reset xOut", int'(xOut), 0);
    chk("reset yOut", int'(yOut), 0);
    reset = 1'b0;

    // Vertical line, literal pixels and done timing
    issue(1, 3, 4, 9, 2);
    expect_pix("vline p0", 3, 4);
    expect_pix("vline p1", 3, 5);
    expect_pix("vline p2", 3, 6);
    chk("vline done", int'(done), 1);
    @(negedge clk);
    chk("vline idle", int'(busy), 0);

    // Horizontal wrap past the coordinate range
    issue(0, 30, 0, 3, 7);
    expect_pix("wrap p0", 30, 0);
    expect_pix("wrap p1", 31, 0);
    expect_pix("wrap p2", 0, 0);
    expect_pix("wrap p3", 1, 0);
    chk("wrap done", int'(done), 1);
    @(negedge clk);

    // Fill 2x2: four pixels, done in cycle 5
    issue(2, 0, 0, 1, 1);
    expect_pix("fill p0", 0, 0);
    expect_pix("fill p1", 0, 1);
    expect_pix("fill p2", 1, 0);
    expect_pix("fill p3", 1, 1);
    chk("fill done", int'(done), 1);
    @(negedge clk);

    // Single pixel from zero extents
    run_draw(2, 7, 9, 0, 0, 0, -1, 0, 1'b0, cyc, np);
    chk("single cycles", cyc, 1);

    // Outline 3x3
    run_draw(3, 5, 5, 2, 2, 0, -1, 0, 1'b0, cyc, np);
    chk("outline plots", np, OUTLINE_ON ? 8 : 9);
    chk("outline cycles", cyc, 9);

    // Stall two cycles on second pixel of a vertical line, start poked mid-draw
    run_draw(1, 3, 4, 0, 2, 0, 1, 2, 1'b1, cyc, np);
    chk("stall cycles", cyc, 5);

    // Reset in the middle of a fill
    issue(2, 2, 3, 2, 2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", int'(busy), 0);
    chk("midreset plot", int'(plot), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset xOut", int'(xOut), 0);
    chk("midreset yOut", int'(yOut), 0);
    @(negedge clk);
    chk("midreset no done", int'(done), 0);
    run_draw(2, 1, 1, 1, 2, 0, -1, 0, 1'b0, cyc, np);
    chk("post-reset cycles", cyc, 6);

    // Random shapes with random stall and stray starts
    for (int t = 0; t < 40; t++) begin
      m  = $urandom_range(3);
      ox = $urandom_range(CMOD - 1);
      oy = $urandom_range(CMOD - 1);
      w  = ($urandom_range(7) == 0) ? $urandom_range(31) : $urandom_range(6);
      h  = ($urandom_range(7) == 0) ? $urandom_range(31) : $urandom_range(6);
      run_draw(m, ox, oy, w, h, 30, -1, 0, 1'b1, cyc, np);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
